uart_fifo_bridge: RTL and testbench
===================================

# uart_fifo_bridge

- Parametrised successor to the single-byte UART echo buffer on the board top level.
- Sits between the direct-serial receiver/transmitter pair (`async_receiver`/`async_transmitter`) and the CPU/bus side.
- Provides independent RX and TX FIFOs, a transmit sequencer, and sticky overrun reporting.
- Optional compiled-in loopback path streams received bytes straight back out.

## Interface
Parameters:
- `DATA_W`, 8: character width in bits.
- `RX_DEPTH`, 16: RX FIFO entries; power of two, ≥2.
- `TX_DEPTH`, 16: TX FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_ready_i`  in  1  receiver data-ready flag; level, held until cleared.
- `rx_data_i`  in  DATA_W  received byte, valid while `rx_ready_i`=1.
- `rx_clear_o`  out  1  one-cycle pulse clearing the receiver flag.
- `tx_busy_i`  in  1  transmitter busy.
- `tx_start_o`  out  1  one-cycle start pulse to the transmitter.
- `tx_data_o`  out  DATA_W  byte to transmit; held stable until the next start.
- `rx_pop_i`  in  1  bus consumes the RX head.
- `rx_dout_o`  out  DATA_W  RX head, first-word-fall-through; 0 when empty.
- `rx_empty_o`  out  1  RX FIFO empty.
- `rx_count_o`  out  clog2(RX_DEPTH)+1  RX occupancy.
- `tx_push_i`  in  1  bus writes `tx_din_i` into the TX FIFO.
- `tx_din_i`  in  DATA_W  byte to enqueue.
- `tx_full_o`  out  1  TX FIFO full.
- `tx_count_o`  out  clog2(TX_DEPTH)+1  TX occupancy.
- `overrun_o`  out  1  sticky: a received byte was dropped.
- `overrun_clr_i`  in  1  clears `overrun_o`.
- `loopback_i`  in  1  loopback enable; present only with `UART_LOOPBACK_EN`.

## Operation
RX capture:
- Capture when `rx_ready_i`=1 and `rx_clear_o` is 0 in the same cycle.
- Next cycle, `rx_clear_o`=1 for exactly one cycle.
- The receiver flag is still high in the clear cycle. That cycle never captures, so there is no double capture.
- If the RX FIFO is full at capture, the byte is dropped. The flag is still cleared and `overrun_o` sets.
- If set and `overrun_clr_i` coincide, set wins.

Bus side:
- `rx_pop_i` while empty is ignored.
- `tx_push_i` is accepted only if the TX count before the edge is below `TX_DEPTH`. A push onto a full FIFO is dropped, even with a simultaneous pop.
- Capture and pop in the same cycle are both performed; the count is unchanged.
- Pointers wrap modulo depth. Counts run 0..DEPTH.

TX sequencer FSM:
- IDLE → START when the TX FIFO is non-empty and `tx_busy_i`=0.
  - Registers the head into `tx_data_o` and pops the FIFO on that edge.
- START: `tx_start_o`=1 for one cycle → HOLD.
- HOLD: one cycle; `tx_busy_i` is ignored while the transmitter raises busy → WAIT.
- WAIT: stays until `tx_busy_i`=0 → IDLE.
- Back-to-back bytes are therefore at least 4 cycles apart, plus the transmitter busy time.

Reset:
- Empties both FIFOs, sends the FSM to IDLE, and clears overrun.
- Reset mid-character abandons the byte. The transmitter finishes its frame on its own.

## Timing
Reset values:
- `rx_clear_o`=0, `tx_start_o`=0, `tx_data_o`=0.
- `rx_empty_o`=1, `rx_count_o`=0, `rx_dout_o`=0.
- `tx_full_o`=0, `tx_count_o`=0, `overrun_o`=0.

Latencies and output types:
- RX latency: a byte captured at edge N is visible on `rx_dout_o` and reflected in `rx_count_o`/`rx_empty_o` after edge N.
- TX latency: a push at edge N, with the FSM idle and not busy, gives `tx_start_o`=1 in cycle N+2.
- Status outputs are registered.
- `rx_dout_o` is combinational from FIFO storage plus the registered read pointer.

## Configuration
`UART_LOOPBACK_EN` defined:
- Adds port `loopback_i`.
- When `loopback_i`=1, each cycle with RX non-empty and TX not full moves one byte from the RX head to the TX tail.
- In that mode `rx_pop_i` and `tx_push_i` are ignored.

`UART_LOOPBACK_EN` not defined:
- The port and path are absent.
- The block behaves as if `loopback_i`=0.

## Test plan
- Reset, then `rx_ready_i`=1 with `rx_data_i`=0x41, held for 2 cycles → single capture.
  - `rx_clear_o` pulses once, `rx_count_o`=1, `rx_dout_o`=0x41.
  - `rx_pop_i` then gives empty and `rx_dout_o`=0.
- Deliver 17 bytes 0x00..0x10 with `RX_DEPTH`=16 → count 16, `overrun_o`=1.
  - Pops return 0x00..0x0F in order.
  - `overrun_clr_i` clears overrun.
- Push 0x55, 0xAA with the transmitter model raising busy 1 cycle after start for 10 cycles.
  - Two `tx_start_o` pulses, with `tx_data_o` 0x55 then 0xAA.
  - The second pulse is never issued while busy=1.
- Fill TX to 16 while busy is held high, then push 0x99 with a simultaneous... FSM blocked → `tx_full_o`=1, the push is dropped, and count stays 16.
- Wrap-around: 40 interleaved capture/pop pairs → data integrity kept and counts never exceed depth.
- With `UART_LOOPBACK_EN` and `loopback_i`=1, receive 0x31, 0x32 → transmitted as 0x31, 0x32 in order, with `rx_empty_o`=1 afterwards.

Source files
------------

// File: rtl/uart_fifo_bridge.sv
// UART byte bridge: RX/TX FIFOs between a serial receiver/transmitter pair and a bus,
// with a TX start sequencer and sticky overrun. Define UART_LOOPBACK_EN to add the loopback path.
module uart_fifo_bridge #(
  parameter int DATA_W   = 8,
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_ready_i,
  input  logic [DATA_W-1:0]           rx_data_i,
  output logic                        rx_clear_o,
  input  logic                        tx_busy_i,
  output logic                        tx_start_o,
  output logic [DATA_W-1:0]           tx_data_o,
  input  logic                        rx_pop_i,
  output logic [DATA_W-1:0]           rx_dout_o,
  output logic                        rx_empty_o,
  output logic [$clog2(RX_DEPTH):0]   rx_count_o,
  input  logic                        tx_push_i,
  input  logic [DATA_W-1:0]           tx_din_i,
  output logic                        tx_full_o,
  output logic [$clog2(TX_DEPTH):0]   tx_count_o,
  output logic                        overrun_o,
  input  logic                        overrun_clr_i
`ifdef UART_LOOPBACK_EN
  ,
  input  logic                        loopback_i
`endif
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [RX_AW:0] RX_CNT_MAX = RX_DEPTH[RX_AW:0];
  localparam logic [TX_AW:0] TX_CNT_MAX = TX_DEPTH[TX_AW:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_HOLD,
    S_WAIT
  } tx_state_t;

  // ---------------------------------------------------------------- storage/state
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];

  logic [RX_AW-1:0]  rx_wr_ptr, rx_rd_ptr;
  logic [RX_AW:0]    rx_count_q, rx_count_nxt;
  logic              rx_empty_q, rx_clear_q, overrun_q;

  logic [TX_AW-1:0]  tx_wr_ptr, tx_rd_ptr;
  logic [TX_AW:0]    tx_count_q, tx_count_nxt;
  logic              tx_empty_q, tx_full_q, tx_start_q;
  logic [DATA_W-1:0] tx_data_q;

  tx_state_t         state_q, state_nxt;

  logic              lb_mode, lb_move;
  logic              capture, rx_full, rx_wr, rx_rd;
  logic              tx_wr, tx_rd;
  logic [DATA_W-1:0] rx_head, tx_wdata;

`ifdef UART_LOOPBACK_EN
  assign lb_mode = loopback_i;
`else
  assign lb_mode = 1'b0;
`endif

  // ---------------------------------------------------------------- datapath control
  // The receiver flag is still high during the clear cycle, so that cycle must not capture.
  assign capture  = rx_ready_i & ~rx_clear_q;
  assign rx_full  = (rx_count_q == RX_CNT_MAX);
  assign rx_wr    = capture & ~rx_full;
  assign rx_head  = rx_mem[rx_rd_ptr];

  assign lb_move  = lb_mode & ~rx_empty_q & ~tx_full_q;
  assign rx_rd    = lb_mode ? lb_move : (rx_pop_i & ~rx_empty_q);
  assign tx_wr    = lb_mode ? lb_move : (tx_push_i & ~tx_full_q);
  assign tx_wdata = lb_mode ? rx_head : tx_din_i;

  assign rx_count_nxt = rx_count_q + {{RX_AW{1'b0}}, rx_wr} - {{RX_AW{1'b0}}, rx_rd};
  assign tx_count_nxt = tx_count_q + {{TX_AW{1'b0}}, tx_wr} - {{TX_AW{1'b0}}, tx_rd};

  // ---------------------------------------------------------------- FIFO storage
  // NOTE: the data arrays carry no reset; occupancy and pointers alone define validity,
  // which keeps the arrays mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_wr_ptr] <= rx_data_i;
    if (tx_wr) tx_mem[tx_wr_ptr] <= tx_wdata;
  end

  // ---------------------------------------------------------------- RX side
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
      rx_count_q <= '0;
      rx_empty_q <= 1'b1;
      rx_clear_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_clear_q <= capture;
      if (rx_wr) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_rd) rx_rd_ptr <= rx_rd_ptr + 1'b1;
      rx_count_q <= rx_count_nxt;
      rx_empty_q <= (rx_count_nxt == '0);
      if (capture && rx_full) overrun_q <= 1'b1;
      else if (overrun_clr_i) overrun_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- TX FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr  <= '0;
      tx_rd_ptr  <= '0;
      tx_count_q <= '0;
      tx_empty_q <= 1'b1;
      tx_full_q  <= 1'b0;
    end else begin
      if (tx_wr) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_rd) tx_rd_ptr <= tx_rd_ptr + 1'b1;
      tx_count_q <= tx_count_nxt;
      tx_empty_q <= (tx_count_nxt == '0);
      tx_full_q  <= (tx_count_nxt == TX_CNT_MAX);
    end
  end

  // ---------------------------------------------------------------- TX sequencer
  // HOLD gives the transmitter one cycle to raise busy before WAIT starts watching it.
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state_q;
    tx_rd     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!tx_empty_q && !tx_busy_i) begin
          state_nxt = S_START;
          tx_rd     = 1'b1;
        end
      end
      S_START: state_nxt = S_HOLD;
      S_HOLD:  state_nxt = S_WAIT;
      S_WAIT:  if (!tx_busy_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_nxt;
      tx_start_q <= tx_rd;
      if (tx_rd) tx_data_q <= tx_mem[tx_rd_ptr];
    end
  end

  // ---------------------------------------------------------------- outputs
  assign rx_clear_o = rx_clear_q;
  assign rx_dout_o  = rx_empty_q ? '0 : rx_head;
  assign rx_empty_o = rx_empty_q;
  assign rx_count_o = rx_count_q;
  assign overrun_o  = overrun_q;
  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
  assign tx_full_o  = tx_full_q;
  assign tx_count_o = tx_count_q;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed self-checking bench for uart_fifo_bridge with a simple transmitter busy model.
module tb_uart_fifo_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_ready, rx_clear, tx_busy, tx_start;
  logic [7:0] rx_data, tx_data, rx_dout, tx_din;
  logic       rx_pop, rx_empty, tx_push, tx_full, overrun, overrun_clr;
  logic [4:0] rx_count, tx_count;
`ifdef UART_LOOPBACK_EN
  logic       loopback;
`endif

  int total = 0;
  int bad   = 0;
  int clr_pulses = 0;
  bit busy_hold = 1'b0;
  logic [7:0] start_log [$];

  always #5 clk = ~clk;

  uart_fifo_bridge #(.DATA_W(8), .RX_DEPTH(16), .TX_DEPTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_ready_i    (rx_ready),
    .rx_data_i     (rx_data),
    .rx_clear_o    (rx_clear),
    .tx_busy_i     (tx_busy),
    .tx_start_o    (tx_start),
    .tx_data_o     (tx_data),
    .rx_pop_i      (rx_pop),
    .rx_dout_o     (rx_dout),
    .rx_empty_o    (rx_empty),
    .rx_count_o    (rx_count),
    .tx_push_i     (tx_push),
    .tx_din_i      (tx_din),
    .tx_full_o     (tx_full),
    .tx_count_o    (tx_count),
    .overrun_o     (overrun),
    .overrun_clr_i (overrun_clr)
`ifdef UART_LOOPBACK_EN
    ,
    .loopback_i    (loopback)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Transmitter model: busy rises the cycle after a start and stays high for 10 cycles.
  initial begin
    bit start_seen;
    int busy_cnt;
    busy_cnt = 0;
    tx_busy  = 1'b0;
    forever begin
      @(negedge clk);
      start_seen = tx_start;
      if (rx_clear) clr_pulses++;
      if (tx_start) begin
        check("start_while_busy", {31'd0, tx_busy}, 32'd0);
        start_log.push_back(tx_data);
      end
      @(posedge clk);
      #1;
      if (start_seen) busy_cnt = 10;
      else if (busy_cnt > 0) busy_cnt--;
      tx_busy = busy_hold || (busy_cnt > 0);
    end
  end

  task automatic deliver(input logic [7:0] d);
    rx_data  = d;
    rx_ready = 1'b1;
    tick;
    tick;
    rx_ready = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check(tag, {24'd0, rx_dout}, {24'd0, exp});
    rx_pop = 1'b1;
    tick;
    rx_pop = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget);
    int cyc;
    cyc = 0;
    while (start_log.size() < n && cyc < budget) begin
      tick;
      cyc++;
    end
    check("start_count", start_log.size(), n);
  endtask

  initial begin
    logic [7:0] exp_q [$];
    rst = 1'b1;
    rx_ready = 1'b0; rx_data = '0; rx_pop = 1'b0;
    tx_push = 1'b0; tx_din = '0; overrun_clr = 1'b0;
`ifdef UART_LOOPBACK_EN
    loopback = 1'b0;
`endif
    repeat (3) tick;
    rst = 1'b0;

    // Reset values
    check("rst_rx_clear", {31'd0, rx_clear}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data",  {24'd0, tx_data},  32'd0);
    check("rst_rx_empty", {31'd0, rx_empty}, 32'd1);
    check("rst_rx_count", {27'd0, rx_count}, 32'd0);
    check("rst_rx_dout",  {24'd0, rx_dout},  32'd0);
    check("rst_tx_full",  {31'd0, tx_full},  32'd0);
    check("rst_tx_count", {27'd0, tx_count}, 32'd0);
    check("rst_overrun",  {31'd0, overrun},  32'd0);

    // Single capture with the ready flag held through the clear cycle
    clr_pulses = 0;
    rx_data = 8'h41; rx_ready = 1'b1;
    tick;
    check("cap_clear_hi", {31'd0, rx_clear}, 32'd1);
    check("cap_count",    {27'd0, rx_count}, 32'd1);
    check("cap_dout",     {24'd0, rx_dout},  32'h41);
    tick;
    check("cap_clear_lo", {31'd0, rx_clear}, 32'd0);
    check("cap_no_dup",   {27'd0, rx_count}, 32'd1);
    rx_ready = 1'b0;
    tick;
    check("cap_pulses",   clr_pulses, 32'd1);
    pop_expect("cap_pop", 8'h41);
    check("pop_empty",    {31'd0, rx_empty}, 32'd1);
    check("pop_dout0",    {24'd0, rx_dout},  32'd0);
    pop_expect("pop_on_empty", 8'h00);
    check("pop_empty_cnt", {27'd0, rx_count}, 32'd0);

    // Overflow: 17 bytes into a 16-deep RX FIFO
    for (int i = 0; i <= 16; i++) deliver(8'(i));
    check("ovf_count",   {27'd0, rx_count}, 32'd16);
    check("ovf_overrun", {31'd0, overrun},  32'd1);
    for (int i = 0; i < 16; i++) pop_expect($sformatf("ovf_pop%0d", i), 8'(i));
    check("ovf_drained", {31'd0, rx_empty}, 32'd1);
    check("ovf_sticky",  {31'd0, overrun},  32'd1);
    overrun_clr = 1'b1;
    tick;
    overrun_clr = 1'b0;
    check("ovf_cleared", {31'd0, overrun},  32'd0);

    // Two transmissions with latency check
    start_log.delete();
    tx_din = 8'h55; tx_push = 1'b1;
    tick;
    tx_din = 8'hAA;
    tick;
    tx_push = 1'b0;
    check("tx_lat_start", {31'd0, tx_start}, 32'd1);
    check("tx_lat_data",  {24'd0, tx_data},  32'h55);
    check("tx_lat_count", {27'd0, tx_count}, 32'd1);
    wait_starts(2, 80);
    if (start_log.size() >= 2) begin
      check("tx_byte0", {24'd0, start_log[0]}, 32'h55);
      check("tx_byte1", {24'd0, start_log[1]}, 32'hAA);
    end

    // Fill TX while the transmitter is held busy, then overfill
    busy_hold = 1'b1;
    repeat (2) tick;
    start_log.delete();
    for (int i = 0; i < 16; i++) begin
      tx_din = 8'h10 + 8'(i); tx_push = 1'b1;
      tick;
    end
    tx_push = 1'b0;
    check("fill_count", {27'd0, tx_count}, 32'd16);
    check("fill_full",  {31'd0, tx_full},  32'd1);
    tx_din = 8'h99; tx_push = 1'b1;
    tick;
    tx_push = 1'b0;
    check("ovfill_count", {27'd0, tx_count}, 32'd16);
    check("ovfill_full",  {31'd0, tx_full},  32'd1);
    busy_hold = 1'b0;
    wait_starts(16, 700);
    repeat (30) tick;
    check("drain_no_extra", start_log.size(), 32'd16);
    for (int i = 0; i < 16 && i < start_log.size(); i++)
      check($sformatf("drain%0d", i), {24'd0, start_log[i]}, 32'h10 + i);
    check("drain_count", {27'd0, tx_count}, 32'd0);

    // Wrap-around: simultaneous capture and pop keep occupancy at one
    deliver(8'h80);
    exp_q.push_back(8'h80);
    for (int i = 0; i < 40; i++) begin
      check($sformatf("wrap_dout%0d", i), {24'd0, rx_dout}, {24'd0, exp_q.pop_front()});
      rx_data = 8'h81 + 8'(i); rx_ready = 1'b1; rx_pop = 1'b1;
      exp_q.push_back(8'h81 + 8'(i));
      tick;
      rx_pop = 1'b0;
      check($sformatf("wrap_count%0d", i), {27'd0, rx_count}, 32'd1);
      tick;
      rx_ready = 1'b0;
    end
    pop_expect("wrap_last", exp_q.pop_front());
    check("wrap_empty", {31'd0, rx_empty}, 32'd1);

`ifdef UART_LOOPBACK_EN
    // Loopback: received bytes go straight back out
    start_log.delete();
    loopback = 1'b1;
    deliver(8'h31);
    deliver(8'h32);
    wait_starts(2, 100);
    if (start_log.size() >= 2) begin
      check("lb_byte0", {24'd0, start_log[0]}, 32'h31);
      check("lb_byte1", {24'd0, start_log[1]}, 32'h32);
    end
    check("lb_rx_empty", {31'd0, rx_empty}, 32'd1);
    loopback = 1'b0;
`endif

    repeat (5) tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
